ir_stat_unit: RTL and testbench

- Datapath-side producer of the fields the control FSM consumes.
- On a fetch pulse from the controller, it runs a request/acknowledge read against instruction memory and latches the 32-bit instruction.
- Decodes OPCODE, MM and register/immediate fields from the latched instruction.
- Holds the 4-bit STAT flag register written from ALU results.
- Sits between instruction memory, ALU and ctrl.

---
 rtl/ir_stat_unit.sv | 137 +++++++++++++
 tb/tb_ir_stat_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_stat_unit.sv
// ir_stat_unit: instruction fetch/decode front end and STAT flag register.
// Runs a request/acknowledge read of instruction memory on a FETCH pulse,
// latches the instruction word into IR, exposes decoded fields, and holds
// the 4-bit {N,Z,V,C} status register.
// Optional build macro IR_PARITY_EN adds IM_PAR / PAR_ERR parity checking.
module ir_stat_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST_F,
   input  logic              FETCH,
   input  logic [ADDR_W-1:0] PC,
   output logic              IM_REQ,
   output logic [ADDR_W-1:0] IM_ADDR,
   input  logic              IM_ACK,
   input  logic [31:0]       IM_DATA,
`ifdef IR_PARITY_EN
   input  logic              IM_PAR,
   output logic              PAR_ERR,
`endif
   output logic              FETCH_DONE,
   output logic              FETCH_ERR,
   output logic [3:0]        OPCODE,
   output logic [3:0]        MM,
   output logic [3:0]        RD_ADDR,
   output logic [3:0]        RS_ADDR,
   output logic [3:0]        RT_ADDR,
   output logic [15:0]       IMM,
   input  logic [3:0]        ALU_FLAGS,
   input  logic              STAT_WE,
   input  logic              STAT_CLR,
   output logic [3:0]        STAT,
   output logic              HALT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   logic [1:0]        state;
   logic [31:0]       ir;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       ack_data;

`ifdef IR_PARITY_EN
   logic par_bad;

   // A word whose parity bit disagrees is replaced by a noop.
   assign par_bad  = IM_PAR ^ (^IM_DATA);
   assign ack_data = par_bad ? '0 : IM_DATA;

   // Sticky parity error flag, set on any acknowledged word with bad parity.
   always_ff @(posedge CLK) begin
      if (!RST_F) begin
         PAR_ERR <= 1'b0;
      end else if (state == S_REQ && IM_ACK && par_bad) begin
         PAR_ERR <= 1'b1;
      end
   end
`else
   assign ack_data = IM_DATA;
`endif

   // Fetch sequencer: IDLE -> REQ (wait for ack or timeout) -> DONE -> IDLE.
   always_ff @(posedge CLK) begin
      if (!RST_F) begin
         state     <= S_IDLE;
         ir        <= '0;
         cnt       <= '0;
         IM_REQ    <= 1'b0;
         IM_ADDR   <= '0;
         FETCH_ERR <= 1'b0;
         HALT      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (FETCH && !HALT) begin
                  IM_ADDR <= PC;
                  IM_REQ  <= 1'b1;
                  cnt     <= '0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (IM_ACK) begin
                  ir     <= ack_data;
                  IM_REQ <= 1'b0;
                  state  <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  IM_REQ    <= 1'b0;
                  FETCH_ERR <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (ir[31:28] == 4'hF) begin
                  HALT <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               IM_REQ <= 1'b0;
            end
         endcase
      end
   end

   // Status flags: clear wins over load; independent of fetch activity.
   always_ff @(posedge CLK) begin
      if (!RST_F) begin
         STAT <= '0;
      end else if (STAT_CLR) begin
         STAT <= '0;
      end else if (STAT_WE) begin
         STAT <= ALU_FLAGS;
      end
   end

   // Completion pulse and instruction field decode straight from state/IR.
   always_comb begin
      FETCH_DONE = (state == S_DONE);
      OPCODE     = ir[31:28];
      MM         = ir[27:24];
      RD_ADDR    = ir[23:20];
      RS_ADDR    = ir[19:16];
      RT_ADDR    = ir[15:12];
      IMM        = ir[15:0];
   end

endmodule

// File: tb/tb_ir_stat_unit.sv
// Directed self-checking bench for ir_stat_unit.
module tb_ir_stat_unit;

   logic        CLK = 1'b0;
   logic        RST_F;
   logic        FETCH;
   logic [7:0]  PC;
   logic        IM_REQ;
   logic [7:0]  IM_ADDR;
   logic        IM_ACK;
   logic [31:0] IM_DATA;
   logic        FETCH_DONE;
   logic        FETCH_ERR;
   logic [3:0]  OPCODE, MM, RD_ADDR, RS_ADDR, RT_ADDR;
   logic [15:0] IMM;
   logic [3:0]  ALU_FLAGS;
   logic        STAT_WE;
   logic        STAT_CLR;
   logic [3:0]  STAT;
   logic        HALT;
`ifdef IR_PARITY_EN
   logic        IM_PAR;
   logic        PAR_ERR;
   logic        par_flip = 1'b0;
   assign IM_PAR = (^IM_DATA) ^ par_flip;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int n_req;
   logic done_seen;

   ir_stat_unit #(.ADDR_W(8), .ACK_TIMEOUT(15)) dut (
      .CLK(CLK), .RST_F(RST_F), .FETCH(FETCH), .PC(PC),
      .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK), .IM_DATA(IM_DATA),
`ifdef IR_PARITY_EN
      .IM_PAR(IM_PAR), .PAR_ERR(PAR_ERR),
`endif
      .FETCH_DONE(FETCH_DONE), .FETCH_ERR(FETCH_ERR),
      .OPCODE(OPCODE), .MM(MM), .RD_ADDR(RD_ADDR), .RS_ADDR(RS_ADDR),
      .RT_ADDR(RT_ADDR), .IMM(IMM), .ALU_FLAGS(ALU_FLAGS),
      .STAT_WE(STAT_WE), .STAT_CLR(STAT_CLR), .STAT(STAT), .HALT(HALT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      RST_F = 1'b0; FETCH = 1'b0; PC = '0; IM_ACK = 1'b1; IM_DATA = 32'hFFFF_FFFF;
      ALU_FLAGS = '0; STAT_WE = 1'b0; STAT_CLR = 1'b0;

      // reset for two edges with IM_ACK asserted
      repeat (2) @(negedge CLK);
      chk("rst_req", IM_REQ, 0);
      chk("rst_addr", IM_ADDR, 0);
      chk("rst_done", FETCH_DONE, 0);
      chk("rst_err", FETCH_ERR, 0);
      chk("rst_halt", HALT, 0);
      chk("rst_ir", {OPCODE, MM, RD_ADDR, RS_ADDR, IMM}, 0);
      chk("rst_stat", STAT, 0);
      RST_F = 1'b1; IM_ACK = 1'b0;
      @(negedge CLK);

      // zero-wait fetch
      FETCH = 1'b1; PC = 8'h05;
      @(negedge CLK);
      FETCH = 1'b0;
      chk("zw_req", IM_REQ, 1);
      chk("zw_addr", IM_ADDR, 8'h05);
      chk("zw_done_early", FETCH_DONE, 0);
      IM_ACK = 1'b1; IM_DATA = 32'h8A31_2345;
      @(negedge CLK);
      IM_ACK = 1'b0;
      chk("zw_done", FETCH_DONE, 1);
      chk("zw_req_low", IM_REQ, 0);
      chk("zw_opcode", OPCODE, 4'h8);
      chk("zw_mm", MM, 4'hA);
      chk("zw_rd", RD_ADDR, 4'h3);
      chk("zw_rs", RS_ADDR, 4'h1);
      chk("zw_rt", RT_ADDR, 4'h2);
      chk("zw_imm", IMM, 16'h2345);
      @(negedge CLK);
      chk("zw_done_once", FETCH_DONE, 0);
      chk("zw_addr_hold", IM_ADDR, 8'h05);

      // fetch with 3 wait states; FETCH during REQ is ignored
      FETCH = 1'b1; PC = 8'h10;
      @(negedge CLK);
      PC = 8'h77;
      for (int i = 0; i < 3; i++) begin
         chk("ws_req", IM_REQ, 1);
         chk("ws_no_done", FETCH_DONE, 0);
         @(negedge CLK);
         FETCH = 1'b0;
      end
      chk("ws_addr", IM_ADDR, 8'h10);
      IM_ACK = 1'b1; IM_DATA = 32'h1234_5678;
      @(negedge CLK);
      IM_ACK = 1'b0;
      chk("ws_done", FETCH_DONE, 1);
      chk("ws_opcode", OPCODE, 4'h1);
      chk("ws_imm", IMM, 16'h5678);
      @(negedge CLK);
      chk("ws_no_requeue", IM_REQ, 0);

      // timeout: no ack at all
      FETCH = 1'b1; PC = 8'h20;
      @(negedge CLK);
      FETCH = 1'b0;
      n_req = 0; done_seen = 1'b0;
      for (int i = 0; i < 40 && IM_REQ; i++) begin
         n_req++;
         @(negedge CLK);
         if (FETCH_DONE) done_seen = 1'b1;
      end
      chk("to_req_cycles", n_req, 15);
      chk("to_err", FETCH_ERR, 1);
      chk("to_no_done", done_seen, 0);
      chk("to_ir_kept", {OPCODE, IMM}, {4'h1, 16'h5678});

      // STAT load, clear priority
      STAT_WE = 1'b1; ALU_FLAGS = 4'b0100;
      @(negedge CLK);
      chk("stat_we", STAT, 4'h4);
      STAT_CLR = 1'b1; ALU_FLAGS = 4'b1011;
      @(negedge CLK);
      STAT_WE = 1'b0; STAT_CLR = 1'b0;
      chk("stat_clr_prio", STAT, 4'h0);

      // STAT write coinciding with ack
      FETCH = 1'b1; PC = 8'h30;
      @(negedge CLK);
      FETCH = 1'b0;
      IM_ACK = 1'b1; IM_DATA = 32'h2000_00FF; STAT_WE = 1'b1; ALU_FLAGS = 4'b1001;
      @(negedge CLK);
      IM_ACK = 1'b0; STAT_WE = 1'b0;
      chk("ov_stat", STAT, 4'h9);
      chk("ov_opcode", OPCODE, 4'h2);
      chk("ov_done", FETCH_DONE, 1);
      @(negedge CLK);

      // ack while idle is ignored
      IM_ACK = 1'b1; IM_DATA = 32'h5555_5555;
      @(negedge CLK);
      IM_ACK = 1'b0;
      chk("idle_ack_ir", OPCODE, 4'h2);
      chk("idle_ack_done", FETCH_DONE, 0);

      // halt instruction
      FETCH = 1'b1; PC = 8'h40;
      @(negedge CLK);
      FETCH = 1'b0;
      IM_ACK = 1'b1; IM_DATA = 32'hF000_0000;
      @(negedge CLK);
      IM_ACK = 1'b0;
      chk("halt_done", FETCH_DONE, 1);
      chk("halt_opcode", OPCODE, 4'hF);
      @(negedge CLK);
      chk("halt_set", HALT, 1);
      FETCH = 1'b1; PC = 8'h41;
      @(negedge CLK);
      FETCH = 1'b0;
      chk("halt_blocks_req", IM_REQ, 0);
      chk("halt_addr_kept", IM_ADDR, 8'h40);

      // reset clears sticky flags
      RST_F = 1'b0;
      @(negedge CLK);
      RST_F = 1'b1;
      chk("rst2_halt", HALT, 0);
      chk("rst2_err", FETCH_ERR, 0);
      chk("rst2_stat", STAT, 0);

      // reset in the middle of a request, then a late ack
      FETCH = 1'b1; PC = 8'h50;
      @(negedge CLK);
      FETCH = 1'b0;
      chk("mid_req", IM_REQ, 1);
      RST_F = 1'b0;
      @(negedge CLK);
      RST_F = 1'b1;
      chk("mid_req_low", IM_REQ, 0);
      IM_ACK = 1'b1; IM_DATA = 32'h7777_7777;
      @(negedge CLK);
      IM_ACK = 1'b0;
      chk("mid_no_done", FETCH_DONE, 0);
      chk("mid_ir_zero", {OPCODE, IMM}, 0);
      chk("mid_addr", IM_ADDR, 0);

`ifdef IR_PARITY_EN
      chk("par_clean", PAR_ERR, 0);
      FETCH = 1'b1; PC = 8'h60;
      @(negedge CLK);
      FETCH = 1'b0;
      IM_ACK = 1'b1; IM_DATA = 32'h8000_0001; par_flip = 1'b1;
      @(negedge CLK);
      IM_ACK = 1'b0; par_flip = 1'b0;
      chk("par_done", FETCH_DONE, 1);
      chk("par_err", PAR_ERR, 1);
      chk("par_noop", {OPCODE, IMM}, 0);
`endif

      @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
